ahb_apb_bridge_ctrl: RTL and testbench

//   AHB-Lite slave to APB master bridge controller for the APB peripheral subsystem.

---
 rtl/ahb_apb_bridge_ctrl.sv | 265 ++++++++++++++++++++++++++
 tb/tb_ahb_apb_bridge_ctrl.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_apb_bridge_ctrl.sv
// ---------------------------------------------------------------------------
// ahb_apb_bridge_ctrl
//
// AHB-Lite slave to APB master bridge controller for the APB peripheral
// subsystem. Every accepted AHB transfer becomes one two-phase APB transfer
// (SETUP then ACCESS). A single PSEL feeds the subsystem's slot decoder, which
// routes on PADDR[15:12]. The AHB data phase is stretched until PREADY.
// PSLVERR, unmapped slots and ACCESS timeouts all produce the two-cycle AHB
// ERROR response.
//
// Parameters
//   ADDR_W    APB address width; slot index is ADDR[ADDR_W-1 -: 4]
//   NUM_SLOTS slots 0..NUM_SLOTS-1 are mapped; higher slots error, no APB cycle
//   TIMEOUT   max ACCESS cycles with PREADY=0 before abort; 0 disables
//   TO_W      timeout counter width
//
// Ports
//   HCLK       in   system clock
//   HRESET     in   asynchronous reset, active-high
//   HSEL       in   AHB slave select
//   HADDR      in   AHB address (low ADDR_W bits)
//   HTRANS     in   AHB transfer type (only bit 1 matters: NONSEQ/SEQ)
//   HWRITE     in   1 = write
//   HREADY     in   AHB bus ready (muxed)
//   HWDATA     in   AHB write data
//   HRDATA     out  read data, registered
//   HREADYOUT  out  slave ready
//   HRESP      out  1 = ERROR
//   PSEL       out  APB select to slot decoder
//   PENABLE    out  APB enable
//   PWRITE     out  APB direction
//   PADDR      out  APB address
//   PWDATA     out  APB write data
//   PRDATA     in   APB read data (muxed)
//   PREADY     in   APB ready (muxed)
//   PSLVERR    in   APB slave error (muxed)
//
// All outputs are driven straight from registers. The next-state logic
// computes the value each output must hold in the next state, so an output
// changes together with the state register.
// ---------------------------------------------------------------------------
module ahb_apb_bridge_ctrl #(
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned NUM_SLOTS = 6,
  parameter int unsigned TIMEOUT   = 255,
  parameter int unsigned TO_W      = 8
) (
  input  logic              HCLK,
  input  logic              HRESET,
  input  logic              HSEL,
  input  logic [ADDR_W-1:0] HADDR,
  input  logic [1:0]        HTRANS,
  input  logic              HWRITE,
  input  logic              HREADY,
  input  logic [31:0]       HWDATA,
  output logic [31:0]       HRDATA,
  output logic              HREADYOUT,
  output logic              HRESP,
  output logic              PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [ADDR_W-1:0] PADDR,
  output logic [31:0]       PWDATA,
  input  logic [31:0]       PRDATA,
  input  logic              PREADY,
  input  logic              PSLVERR
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WDATA  = 3'd1,
    ST_SETUP  = 3'd2,
    ST_ACCESS = 3'd3,
    ST_ERR1   = 3'd4,
    ST_ERR2   = 3'd5
  } state_e;

  // Slot limit is held one bit wider than the slot index so that
  // NUM_SLOTS = 16 (every slot mapped) still compares correctly.
  localparam logic [4:0]      SLOT_LIM = 5'(NUM_SLOTS);
  localparam logic [TO_W-1:0] TO_LIM   = TO_W'(TIMEOUT);
  localparam logic            TO_EN    = (TIMEOUT != 32'd0);
  localparam logic [TO_W-1:0] TO_ONE   = TO_W'(1);
  localparam logic [TO_W-1:0] TO_MAX   = {TO_W{1'b1}};

  // True when the slot index of addr has a peripheral behind it.
  function automatic logic slot_mapped(input logic [ADDR_W-1:0] addr);
    logic [4:0] slot;
    slot = {1'b0, addr[ADDR_W-1 -: 4]};
    return (slot < SLOT_LIM);
  endfunction

  state_e            state_q,     state_d;
  logic [31:0]       hrdata_q,    hrdata_d;
  logic              hreadyout_q, hreadyout_d;
  logic              hresp_q,     hresp_d;
  logic              psel_q,      psel_d;
  logic              penable_q,   penable_d;
  logic              pwrite_q,    pwrite_d;
  logic [ADDR_W-1:0] paddr_q,     paddr_d;
  logic [31:0]       pwdata_q,    pwdata_d;
  logic [TO_W-1:0]   to_cnt_q,    to_cnt_d;

  logic              accept_s;
  logic [TO_W-1:0]   to_cnt_inc_s;
  logic              unused_s;

  // HTRANS[0] only separates IDLE from BUSY and NONSEQ from SEQ, which the
  // bridge treats alike.
  assign unused_s = HTRANS[0];

  // Address phase qualifier; only looked at in IDLE and ERR2.
  assign accept_s = HSEL & HTRANS[1] & HREADY;

  // Wait counter increment, saturating so that TIMEOUT = 0 cannot wrap it.
  always_comb begin
    if (to_cnt_q != TO_MAX) begin
      to_cnt_inc_s = to_cnt_q + TO_ONE;
    end else begin
      to_cnt_inc_s = to_cnt_q;
    end
  end

  // Next-state and next-output logic for the bridge sequencer.
  always_comb begin
    state_d     = state_q;
    hrdata_d    = hrdata_q;
    hreadyout_d = hreadyout_q;
    hresp_d     = hresp_q;
    psel_d      = 1'b0;
    penable_d   = 1'b0;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    to_cnt_d    = to_cnt_q;

    case (state_q)
      // ERR2 is a ready cycle as well, so a new address phase may land here.
      ST_IDLE, ST_ERR2: begin
        if (accept_s) begin
          paddr_d  = HADDR;
          pwrite_d = HWRITE;
          if (!slot_mapped(HADDR)) begin
            state_d     = ST_ERR1;
            hreadyout_d = 1'b0;
            hresp_d     = 1'b1;
          end else if (HWRITE) begin
            state_d     = ST_WDATA;
            hreadyout_d = 1'b0;
            hresp_d     = 1'b0;
          end else begin
            state_d     = ST_SETUP;
            hreadyout_d = 1'b0;
            hresp_d     = 1'b0;
            psel_d      = 1'b1;
          end
        end else begin
          state_d     = ST_IDLE;
          hreadyout_d = 1'b1;
          hresp_d     = 1'b0;
        end
      end

      // HWDATA is valid only in the AHB data phase, one cycle after accept.
      ST_WDATA: begin
        pwdata_d    = HWDATA;
        state_d     = ST_SETUP;
        hreadyout_d = 1'b0;
        hresp_d     = 1'b0;
        psel_d      = 1'b1;
      end

      ST_SETUP: begin
        state_d     = ST_ACCESS;
        hreadyout_d = 1'b0;
        hresp_d     = 1'b0;
        psel_d      = 1'b1;
        penable_d   = 1'b1;
        to_cnt_d    = '0;
      end

      ST_ACCESS: begin
        if (PREADY) begin
          if (PSLVERR) begin
            state_d     = ST_ERR1;
            hreadyout_d = 1'b0;
            hresp_d     = 1'b1;
          end else begin
            state_d     = ST_IDLE;
            hreadyout_d = 1'b1;
            hresp_d     = 1'b0;
            if (!pwrite_q) begin
              hrdata_d = PRDATA;
            end else begin
              hrdata_d = hrdata_q;
            end
          end
        end else if (TO_EN && (to_cnt_inc_s == TO_LIM)) begin
          // Abort: PSEL/PENABLE drop with the move to ERR1.
          state_d     = ST_ERR1;
          hreadyout_d = 1'b0;
          hresp_d     = 1'b1;
          to_cnt_d    = to_cnt_inc_s;
        end else begin
          state_d     = ST_ACCESS;
          hreadyout_d = 1'b0;
          hresp_d     = 1'b0;
          psel_d      = 1'b1;
          penable_d   = 1'b1;
          to_cnt_d    = to_cnt_inc_s;
        end
      end

      // First ERROR cycle holds HREADYOUT low; the second releases it.
      ST_ERR1: begin
        state_d     = ST_ERR2;
        hreadyout_d = 1'b1;
        hresp_d     = 1'b1;
      end

      default: begin
        state_d     = ST_IDLE;
        hreadyout_d = 1'b1;
        hresp_d     = 1'b0;
      end
    endcase
  end

  // State and output registers; reset drops the APB strobes immediately.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q     <= ST_IDLE;
      hrdata_q    <= 32'h0000_0000;
      hreadyout_q <= 1'b1;
      hresp_q     <= 1'b0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= 32'h0000_0000;
      to_cnt_q    <= '0;
    end else begin
      state_q     <= state_d;
      hrdata_q    <= hrdata_d;
      hreadyout_q <= hreadyout_d;
      hresp_q     <= hresp_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      to_cnt_q    <= to_cnt_d;
    end
  end

  assign HRDATA    = hrdata_q;
  assign HREADYOUT = hreadyout_q;
  assign HRESP     = hresp_q;
  assign PSEL      = psel_q;
  assign PENABLE   = penable_q;
  assign PWRITE    = pwrite_q;
  assign PADDR     = paddr_q;
  assign PWDATA    = pwdata_q;

endmodule

// File: tb/tb_ahb_apb_bridge_ctrl.sv
// ---------------------------------------------------------------------------
// Testbench for ahb_apb_bridge_ctrl (NUM_SLOTS=6, TIMEOUT=4).
// The AHB driver pushes the expected response of each transfer to a
// scoreboard when the address phase is presented; the AHB monitor pops and
// compares when the data phase completes. A behavioural APB slave pops its
// own per-transfer response queue at SETUP and checks the APB signalling.
// ---------------------------------------------------------------------------
module tb_ahb_apb_bridge_ctrl;

  localparam int TO_CFG = 4;
  localparam int SLOTS  = 6;
  localparam int BUDGET = 200;

  logic        HCLK;
  logic        HRESET;
  logic        HSEL;
  logic [15:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic        HREADY;
  logic [31:0] HWDATA;
  logic [31:0] HRDATA;
  logic        HREADYOUT;
  logic        HRESP;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [15:0] PADDR;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          low;
  } sb_t;

  typedef struct {
    logic [15:0] addr;
    logic        wr;
    logic [31:0] wdata;
    int          waits;
    logic        slverr;
    logic [31:0] rdata;
    int          acc;
  } apb_t;

  typedef struct {
    logic [15:0] addr;
    logic        wr;
    logic [31:0] wdata;
    int          waits;
    logic        slverr;
    logic [31:0] rdata;
  } stim_t;

  sb_t         sb_q[$];
  apb_t        apb_q[$];
  logic [31:0] model_hrdata;
  int          n_checks = 0;
  int          n_errors = 0;

  ahb_apb_bridge_ctrl #(
    .ADDR_W(16), .NUM_SLOTS(SLOTS), .TIMEOUT(TO_CFG), .TO_W(8)
  ) dut (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HREADY(HREADY), .HWDATA(HWDATA), .HRDATA(HRDATA),
    .HREADYOUT(HREADYOUT), .HRESP(HRESP), .PSEL(PSEL), .PENABLE(PENABLE),
    .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA),
    .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  // Single slave on the bus: the muxed HREADY is our own HREADYOUT.
  assign HREADY = HREADYOUT;

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string pfx);
    chk_val({pfx, "_hreadyout"}, 32'(HREADYOUT), 32'd1);
    chk_val({pfx, "_hresp"},     32'(HRESP),     32'd0);
    chk_val({pfx, "_psel"},      32'(PSEL),      32'd0);
    chk_val({pfx, "_penable"},   32'(PENABLE),   32'd0);
    chk_val({pfx, "_pwrite"},    32'(PWRITE),    32'd0);
    chk_val({pfx, "_paddr"},     32'(PADDR),     32'd0);
    chk_val({pfx, "_pwdata"},    PWDATA,         32'd0);
    chk_val({pfx, "_hrdata"},    HRDATA,         32'd0);
  endtask

  // Called at posedge+1; presents one address phase once the slave is ready,
  // then drives the write data for the following data phase.
  task automatic ahb_xfer(input logic [15:0] addr, input logic wr, input logic [31:0] wdata,
                          input int waits, input logic slverr, input logic [31:0] rdata);
    int   guard;
    sb_t  e;
    apb_t a;
    logic mapped;
    logic tmo;
    logic err;
    int   acc;
    guard = 0;
    while (!HREADYOUT && guard < BUDGET) begin
      @(posedge HCLK); #1;
      guard++;
    end
    if (guard >= BUDGET) chk_val("ahb_ready_wait", 32'(HREADYOUT), 32'd1);
    mapped = ({28'd0, addr[15:12]} < 32'(SLOTS));
    tmo    = mapped && (waits >= TO_CFG);
    err    = !mapped || tmo || slverr;
    acc    = tmo ? TO_CFG : waits + 1;
    if (mapped && !wr && !err) model_hrdata = rdata;
    e.err   = err;
    e.rdata = model_hrdata;
    e.low   = !mapped ? 1 : ((wr ? 2 : 1) + acc + (err ? 1 : 0));
    sb_q.push_back(e);
    if (mapped) begin
      a.addr = addr; a.wr = wr; a.wdata = wdata; a.waits = waits;
      a.slverr = slverr; a.rdata = wr ? (32'hFFFF_0000 ^ {16'd0, addr}) : rdata;
      a.acc = acc;
      apb_q.push_back(a);
    end
    HSEL = 1'b1; HTRANS = 2'b10; HADDR = addr; HWRITE = wr;
    @(posedge HCLK); #1;
    HSEL = 1'b0; HTRANS = 2'b00; HWDATA = wdata;
  endtask

  // AHB monitor: measures wait cycles and checks the completion response.
  initial begin
    logic dph;
    logic last_resp;
    int   lowcnt;
    sb_t  e;
    dph = 1'b0; last_resp = 1'b0; lowcnt = 0;
    forever begin
      @(negedge HCLK);
      if (HRESET) begin
        dph = 1'b0;
        sb_q.delete();
      end else begin
        if (dph) begin
          if (!HREADYOUT) begin
            lowcnt++;
            last_resp = HRESP;
          end else begin
            chk_val("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
            if (sb_q.size() != 0) begin
              e = sb_q.pop_front();
              chk_val("wait_cycles", 32'(lowcnt), 32'(e.low));
              chk_val("hresp_last", 32'(HRESP), 32'(e.err));
              chk_val("hresp_prev", 32'(last_resp), 32'(e.err));
              chk_val("hrdata", HRDATA, e.rdata);
            end
            dph = 1'b0;
          end
        end
        if (HSEL && HTRANS[1] && HREADYOUT) begin
          dph = 1'b1; lowcnt = 0; last_resp = 1'b0;
        end
      end
    end
  end

  // APB slave model: answers from apb_q and checks APB signalling.
  initial begin
    apb_t cur;
    logic cur_v;
    int   cnt;
    int   acc;
    PREADY = 1'b0; PSLVERR = 1'b0; PRDATA = 32'h0;
    cur_v = 1'b0; cnt = 0; acc = 0;
    forever begin
      @(negedge HCLK);
      if (HRESET) begin
        apb_q.delete();
        cur_v = 1'b0; PREADY = 1'b0; PSLVERR = 1'b0;
      end else if (PSEL && !PENABLE) begin
        chk_val("apb_setup_expected", 32'(apb_q.size() != 0), 32'd1);
        if (apb_q.size() != 0) begin
          cur = apb_q.pop_front();
          cur_v = 1'b1; cnt = cur.waits; acc = 0;
          chk_val("setup_paddr", 32'(PADDR), 32'(cur.addr));
          chk_val("setup_pwrite", 32'(PWRITE), 32'(cur.wr));
          if (cur.wr) chk_val("setup_pwdata", PWDATA, cur.wdata);
          PRDATA = cur.rdata;
        end
        PREADY = 1'b0; PSLVERR = 1'b0;
      end else if (PSEL && PENABLE) begin
        chk_val("access_after_setup", 32'(cur_v), 32'd1);
        acc++;
        chk_val("access_paddr", 32'(PADDR), 32'(cur.addr));
        if (cur.wr) chk_val("access_pwdata", PWDATA, cur.wdata);
        if (cnt == 0) begin
          PREADY = 1'b1; PSLVERR = cur.slverr;
        end else begin
          PREADY = 1'b0; PSLVERR = 1'b0; cnt--;
        end
      end else begin
        if (cur_v) begin
          chk_val("penable_cycles", 32'(acc), 32'(cur.acc));
          cur_v = 1'b0;
        end
        PREADY = 1'b0; PSLVERR = 1'b0;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish before 100000");
    $fatal(1, "watchdog expired");
  end

  initial begin
    stim_t tbl[9];
    int    g;
    tbl[0] = '{16'h2004, 1'b0, 32'h0000_0000, 0,  1'b0, 32'hA5A5_0001}; // plain read
    tbl[1] = '{16'h0000, 1'b1, 32'hDEAD_BEEF, 3,  1'b0, 32'h0000_0000}; // write, 3 waits
    tbl[2] = '{16'h1008, 1'b0, 32'h0000_0000, 0,  1'b1, 32'hBAD0_0000}; // PSLVERR read
    tbl[3] = '{16'h7000, 1'b0, 32'h0000_0000, 0,  1'b0, 32'h0000_0000}; // unmapped
    tbl[4] = '{16'h4010, 1'b0, 32'h0000_0000, 1,  1'b0, 32'h1234_5678}; // taken in ERR2
    tbl[5] = '{16'h0FFC, 1'b0, 32'h0000_0000, 10, 1'b0, 32'h5555_AAAA}; // read timeout
    tbl[6] = '{16'h5ABC, 1'b1, 32'h0123_4567, 10, 1'b0, 32'h0000_0000}; // write timeout
    tbl[7] = '{16'h5FFF, 1'b0, 32'h0000_0000, 0,  1'b0, 32'hCAFE_F00D}; // last mapped slot
    tbl[8] = '{16'h6000, 1'b1, 32'h7777_8888, 0,  1'b0, 32'h0000_0000}; // first unmapped slot

    HRESET = 1'b1; HSEL = 1'b0; HTRANS = 2'b00; HADDR = 16'h0; HWRITE = 1'b0;
    HWDATA = 32'h0; model_hrdata = 32'h0;
    repeat (2) @(posedge HCLK);
    #1;
    chk_reset_outputs("por");
    HRESET = 1'b0;
    @(posedge HCLK); #1;

    // BUSY while selected, then NONSEQ while deselected: both ignored.
    HSEL = 1'b1; HTRANS = 2'b01; HADDR = 16'h2000;
    @(posedge HCLK); #1;
    HSEL = 1'b0; HTRANS = 2'b10;
    @(posedge HCLK); #1;
    HTRANS = 2'b00;
    @(posedge HCLK); #1;
    chk_val("ignored_hreadyout", 32'(HREADYOUT), 32'd1);
    chk_val("ignored_psel", 32'(PSEL), 32'd0);

    for (int i = 0; i < 9; i++) begin
      ahb_xfer(tbl[i].addr, tbl[i].wr, tbl[i].wdata, tbl[i].waits, tbl[i].slverr, tbl[i].rdata);
    end
    g = 0;
    while (sb_q.size() != 0 && g < BUDGET) begin
      @(posedge HCLK); #1;
      g++;
    end
    chk_val("sb_drain", 32'(sb_q.size()), 32'd0);

    // Back-to-back write then read; reset lands during the read's ACCESS.
    ahb_xfer(16'h3000, 1'b1, 32'h1111_2222, 0, 1'b0, 32'h0);
    ahb_xfer(16'h5000, 1'b0, 32'h0, 100, 1'b0, 32'h9999_0000);
    g = 0;
    while (!(PSEL && PENABLE) && g < BUDGET) begin
      @(posedge HCLK); #1;
      g++;
    end
    chk_val("b2b_read_access", 32'({PSEL, PENABLE}), 32'd3);
    chk_val("b2b_read_paddr", 32'(PADDR), 32'h0000_5000);
    @(posedge HCLK); #3;
    HRESET = 1'b1;
    model_hrdata = 32'h0;
    #1;
    chk_reset_outputs("async_rst");
    @(negedge HCLK);
    @(posedge HCLK); #1;
    HRESET = 1'b0;

    // Recovery after reset.
    ahb_xfer(16'h2000, 1'b0, 32'h0, 2, 1'b0, 32'h600D_0002);
    g = 0;
    while (sb_q.size() != 0 && g < BUDGET) begin
      @(posedge HCLK); #1;
      g++;
    end
    chk_val("sb_drain_end", 32'(sb_q.size()), 32'd0);
    chk_val("apb_drain_end", 32'(apb_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
